// File: rtl/game_controller_gen.sv
// Top-level game-flow sequencer: maze draw, object placement with bounded retry,
// play/pause, level progression with bonus lives, life loss, win/lose and restart.
module game_controller_gen #(
   parameter int                    NUM_LEVELS      = 5,
   parameter int                    MAX_LIVES       = 3,
   parameter int                    NUM_COLL        = 5,
   parameter logic [NUM_COLL-1:0]   COLL_MASK       = '1,
   parameter int                    PLACE_RETRY_MAX = 8,
   parameter int                    BONUS_EVERY     = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start_of_frame,
   input  logic                                 timer_end,
   input  logic                                 goal_hit,
   input  logic [NUM_COLL-1:0]                  place_coll,
   input  logic                                 pause_req,
   input  logic                                 restart,
   output logic [$clog2(NUM_LEVELS+1)-1:0]      level,
   output logic [$clog2(MAX_LIVES+1)-1:0]       lives,
   output logic                                 draw_maze,
   output logic                                 draw_objects,
   output logic                                 start_timer,
   output logic                                 pause_timer,
   output logic                                 completed_level,
   output logic                                 lose_life,
   output logic                                 maze_regen,
   output logic [$clog2(PLACE_RETRY_MAX+1)-1:0] retry_count,
   output logic                                 flag_win,
   output logic                                 flag_lose
);

   localparam int LW = $clog2(NUM_LEVELS+1);
   localparam int VW = $clog2(MAX_LIVES+1);
   localparam int RW = $clog2(PLACE_RETRY_MAX+1);
   // Divisor kept non-zero so the modulo is always legal; BONUS_EVERY==0 gates it off.
   localparam int BE = (BONUS_EVERY == 0) ? 1 : BONUS_EVERY;

   localparam logic [LW-1:0] LVL_ONE    = LW'(1);
   localparam logic [LW-1:0] LVL_LAST   = LW'(NUM_LEVELS);
   localparam logic [VW-1:0] LIVES_ONE  = VW'(1);
   localparam logic [VW-1:0] LIVES_FULL = VW'(MAX_LIVES);
   localparam logic [RW-1:0] RETRY_LAST = RW'(PLACE_RETRY_MAX-1);

   typedef enum logic [3:0] {
      S_DRAW_MAZE, S_DRAW_OBJ, S_CHECK, S_PLAY, S_PAUSE,
      S_LEVEL_UP, S_LIFE_LOST, S_LOSE, S_WIN
   } state_t;

   state_t          state, state_n;
   logic [LW-1:0]   levels_done, done_n, done_inc, level_n;
   logic [VW-1:0]   lives_n;
   logic [RW-1:0]   retry_n;
   logic            st_n, ll_n, mr_n;
   logic            hit, bonus;

   assign hit      = |(place_coll & COLL_MASK);
   assign done_inc = levels_done + 1'b1;
   assign bonus    = (BONUS_EVERY != 0) && ((int'(done_inc) % BE) == 0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_DRAW_MAZE;
         level       <= LVL_ONE;
         lives       <= LIVES_FULL;
         retry_count <= '0;
         levels_done <= '0;
         start_timer <= 1'b0;
         lose_life   <= 1'b0;
         maze_regen  <= 1'b0;
      end else begin
         state       <= state_n;
         level       <= level_n;
         lives       <= lives_n;
         retry_count <= retry_n;
         levels_done <= done_n;
         start_timer <= st_n;
         lose_life   <= ll_n;
         maze_regen  <= mr_n;
      end
   end

   always_comb begin
      state_n = state;
      level_n = level;
      lives_n = lives;
      retry_n = retry_count;
      done_n  = levels_done;
      st_n    = 1'b0;
      ll_n    = 1'b0;
      mr_n    = 1'b0;
      case (state)
         S_DRAW_MAZE: begin
            state_n = S_DRAW_OBJ;
            retry_n = '0;
         end
         S_DRAW_OBJ:
            if (start_of_frame) state_n = S_CHECK;
         S_CHECK: begin
            // Placement collision outranks a frame start; the last allowed retry
            // abandons this maze instead of trying again.
            if (hit && retry_count == RETRY_LAST) begin
               state_n = S_DRAW_MAZE;
               mr_n    = 1'b1;
               retry_n = '0;
            end else if (hit) begin
               state_n = S_DRAW_OBJ;
               retry_n = retry_count + 1'b1;
            end else if (start_of_frame) begin
               state_n = S_PLAY;
               st_n    = 1'b1;
            end
         end
         S_PLAY: begin
            if (timer_end) begin
               ll_n    = 1'b1;
               lives_n = lives - 1'b1;
               state_n = (lives > LIVES_ONE) ? S_LIFE_LOST : S_LOSE;
            end else if (goal_hit) begin
               state_n = (level == LVL_LAST) ? S_WIN : S_LEVEL_UP;
            end else if (pause_req) begin
               state_n = S_PAUSE;
            end
         end
         S_PAUSE:
            if (pause_req) state_n = S_PLAY;
         S_LIFE_LOST:
            state_n = S_DRAW_MAZE;
         S_LEVEL_UP: begin
            state_n = S_DRAW_MAZE;
            level_n = level + 1'b1;
            done_n  = done_inc;
            if (bonus && lives < LIVES_FULL) lives_n = lives + 1'b1;
         end
         S_LOSE, S_WIN: begin
            if (restart) begin
               state_n = S_DRAW_MAZE;
               level_n = LVL_ONE;
               lives_n = LIVES_FULL;
               done_n  = '0;
            end
         end
         default: state_n = S_DRAW_MAZE;
      endcase
   end

   assign draw_maze       = (state == S_DRAW_MAZE);
   assign draw_objects    = (state == S_DRAW_OBJ);
   assign pause_timer     = (state == S_PAUSE);
   assign completed_level = (state == S_LEVEL_UP);
   assign flag_win        = (state == S_WIN);
   assign flag_lose       = (state == S_LOSE);

endmodule

// File: tb/tb_game_controller_gen.sv
// Directed bench for game_controller_gen: reset, placement retry, life loss,
// progression with bonus lives, input priority and pause.
module tb_game_controller_gen;

   logic       clk = 1'b0;
   logic       reset, start_of_frame, timer_end, goal_hit, pause_req, restart;
   logic [4:0] place_coll;
   logic [2:0] level;
   logic [1:0] lives;
   logic [3:0] retry_count;
   logic       draw_maze, draw_objects, start_timer, pause_timer;
   logic       completed_level, lose_life, maze_regen, flag_win, flag_lose;

   int n_chk  = 0;
   int n_fail = 0;

   // Channel 0 is masked off so it never blocks placement.
   game_controller_gen #(.COLL_MASK(5'b11110)) dut (
      .clk(clk), .reset(reset), .start_of_frame(start_of_frame),
      .timer_end(timer_end), .goal_hit(goal_hit), .place_coll(place_coll),
      .pause_req(pause_req), .restart(restart), .level(level), .lives(lives),
      .draw_maze(draw_maze), .draw_objects(draw_objects), .start_timer(start_timer),
      .pause_timer(pause_timer), .completed_level(completed_level),
      .lose_life(lose_life), .maze_regen(maze_regen), .retry_count(retry_count),
      .flag_win(flag_win), .flag_lose(flag_lose)
   );

   always #5 clk = ~clk;

   // Flag/pulse outputs packed for compact comparison.
   wire [8:0] outs = {draw_maze, draw_objects, start_timer, pause_timer,
                      completed_level, lose_life, maze_regen, flag_win, flag_lose};
   localparam logic [8:0] DM = 9'h100, DO = 9'h080, ST = 9'h040, PT = 9'h020,
                          CL = 9'h010, LL = 9'h008, MR = 9'h004, FW = 9'h002,
                          FL = 9'h001, NONE = 9'h000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Walks from DRAW_MAZE/LIFE_LOST/LEVEL_UP through DRAW_OBJ and CHECK into PLAY.
   task automatic go_play(input string tag);
      for (int i = 0; i < 20 && !draw_objects; i++) tick();
      n_chk++;
      if (draw_objects !== 1'b1) begin
         n_fail++; $display("FAIL %s reach_draw_obj got %0d want 1", tag, draw_objects);
      end
      start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
      start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
      n_chk++;
      if (outs !== ST) begin
         n_fail++; $display("FAIL %s enter_play outs got %h want %h", tag, outs, ST);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      n_chk++;
      if (outs !== DM || level !== 3'd1 || lives !== 2'd3 || retry_count !== 4'd0) begin
         n_fail++; $display("FAIL reset_vals outs=%h lvl=%0d lives=%0d retry=%0d want %h/1/3/0",
                            outs, level, lives, retry_count, DM);
      end
      tick();
      n_chk++;
      if (outs !== DO) begin
         n_fail++; $display("FAIL reset_draw_obj outs got %h want %h", outs, DO);
      end
   endtask

   task automatic test_clean_start();
      do_reset(); tick();
      for (int i = 0; i < 5; i++) tick();
      n_chk++;
      if (outs !== DO) begin
         n_fail++; $display("FAIL clean_hold_obj outs got %h want %h", outs, DO);
      end
      start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      n_chk++;
      if (outs !== NONE) begin
         n_fail++; $display("FAIL clean_check_wait outs got %h want %h", outs, NONE);
      end
      start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
      n_chk++;
      if (outs !== ST || level !== 3'd1 || lives !== 2'd3) begin
         n_fail++; $display("FAIL clean_play outs=%h lvl=%0d lives=%0d want %h/1/3", outs, level, lives, ST);
      end
      tick();
      n_chk++;
      if (outs !== NONE) begin
         n_fail++; $display("FAIL clean_single_start outs got %h want %h", outs, NONE);
      end
   endtask

   task automatic test_retry();
      do_reset(); tick();
      place_coll = 5'b00100;
      for (int k = 1; k <= 7; k++) begin
         start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
         tick();
         n_chk++;
         if (outs !== DO || retry_count !== 4'(k)) begin
            n_fail++; $display("FAIL retry_step%0d outs=%h retry=%0d want %h/%0d", k, outs, retry_count, DO, k);
         end
      end
      start_of_frame = 1'b1; tick(); start_of_frame = 1'b0;
      tick();
      n_chk++;
      if (outs !== (DM | MR) || retry_count !== 4'd0) begin
         n_fail++; $display("FAIL retry_regen outs=%h retry=%0d want %h/0", outs, retry_count, DM | MR);
      end
      tick();
      n_chk++;
      if (outs !== DO) begin
         n_fail++; $display("FAIL retry_after_regen outs got %h want %h", outs, DO);
      end
      place_coll = 5'b00001;
      start_of_frame = 1'b1; tick(); tick(); start_of_frame = 1'b0;
      n_chk++;
      if (outs !== ST || retry_count !== 4'd0) begin
         n_fail++; $display("FAIL retry_masked outs=%h retry=%0d want %h/0", outs, retry_count, ST);
      end
      place_coll = 5'b0;
   endtask

   task automatic test_life_loss();
      do_reset();
      go_play("life1");
      timer_end = 1'b1; tick(); timer_end = 1'b0;
      n_chk++;
      if (outs !== LL || lives !== 2'd2) begin
         n_fail++; $display("FAIL life_first outs=%h lives=%0d want %h/2", outs, lives, LL);
      end
      tick();
      n_chk++;
      if (outs !== DM || level !== 3'd1) begin
         n_fail++; $display("FAIL life_redraw outs=%h lvl=%0d want %h/1", outs, level, DM);
      end
      go_play("life2");
      timer_end = 1'b1; tick(); timer_end = 1'b0;
      n_chk++;
      if (outs !== LL || lives !== 2'd1) begin
         n_fail++; $display("FAIL life_second outs=%h lives=%0d want %h/1", outs, lives, LL);
      end
      go_play("life3");
      timer_end = 1'b1; tick(); timer_end = 1'b0;
      n_chk++;
      if (outs !== (LL | FL) || lives !== 2'd0) begin
         n_fail++; $display("FAIL life_lose outs=%h lives=%0d want %h/0", outs, lives, LL | FL);
      end
      timer_end = 1'b1; goal_hit = 1'b1; pause_req = 1'b1; start_of_frame = 1'b1;
      tick(); tick();
      timer_end = 1'b0; goal_hit = 1'b0; pause_req = 1'b0; start_of_frame = 1'b0;
      n_chk++;
      if (outs !== FL || lives !== 2'd0) begin
         n_fail++; $display("FAIL life_lose_hold outs=%h lives=%0d want %h/0", outs, lives, FL);
      end
      restart = 1'b1; tick(); restart = 1'b0;
      n_chk++;
      if (outs !== DM || level !== 3'd1 || lives !== 2'd3) begin
         n_fail++; $display("FAIL life_restart outs=%h lvl=%0d lives=%0d want %h/1/3", outs, level, lives, DM);
      end
   endtask

   task automatic test_progression();
      logic [1:0] exp_lives;
      do_reset();
      go_play("prog0");
      timer_end = 1'b1; tick(); timer_end = 1'b0;
      for (int l = 1; l <= 4; l++) begin
         go_play("prog");
         goal_hit = 1'b1; tick(); goal_hit = 1'b0;
         n_chk++;
         if (outs !== CL || level !== 3'(l)) begin
            n_fail++; $display("FAIL prog_levelup%0d outs=%h lvl=%0d want %h/%0d", l, outs, level, CL, l);
         end
         tick();
         exp_lives = (l >= 2) ? 2'd3 : 2'd2;
         n_chk++;
         if (outs !== DM || level !== 3'(l + 1) || lives !== exp_lives) begin
            n_fail++; $display("FAIL prog_next%0d outs=%h lvl=%0d lives=%0d want %h/%0d/%0d",
                               l, outs, level, lives, DM, l + 1, exp_lives);
         end
      end
      go_play("prog5");
      goal_hit = 1'b1; tick(); goal_hit = 1'b0;
      n_chk++;
      if (outs !== FW || level !== 3'd5 || lives !== 2'd3) begin
         n_fail++; $display("FAIL prog_win outs=%h lvl=%0d lives=%0d want %h/5/3", outs, level, lives, FW);
      end
      restart = 1'b1; tick(); restart = 1'b0;
      n_chk++;
      if (outs !== DM || level !== 3'd1 || lives !== 2'd3) begin
         n_fail++; $display("FAIL prog_restart outs=%h lvl=%0d lives=%0d want %h/1/3", outs, level, lives, DM);
      end
   endtask

   task automatic test_priority();
      do_reset();
      go_play("prio");
      timer_end = 1'b1; goal_hit = 1'b1; pause_req = 1'b1; tick();
      timer_end = 1'b0; goal_hit = 1'b0; pause_req = 1'b0;
      n_chk++;
      if (outs !== LL || lives !== 2'd2 || level !== 3'd1) begin
         n_fail++; $display("FAIL prio_play outs=%h lives=%0d lvl=%0d want %h/2/1", outs, lives, level, LL);
      end
      tick(); tick();
      place_coll = 5'b00100;
      start_of_frame = 1'b1; tick(); tick(); start_of_frame = 1'b0;
      place_coll = 5'b0;
      n_chk++;
      if (outs !== DO || retry_count !== 4'd1) begin
         n_fail++; $display("FAIL prio_check outs=%h retry=%0d want %h/1", outs, retry_count, DO);
      end
      start_of_frame = 1'b1; tick(); tick(); start_of_frame = 1'b0;
      n_chk++;
      if (outs !== ST || retry_count !== 4'd1) begin
         n_fail++; $display("FAIL prio_retry_hold outs=%h retry=%0d want %h/1", outs, retry_count, ST);
      end
   endtask

   task automatic test_pause();
      do_reset();
      go_play("pause0");
      goal_hit = 1'b1; tick(); goal_hit = 1'b0;
      go_play("pause1");
      pause_req = 1'b1; tick(); pause_req = 1'b0;
      n_chk++;
      if (outs !== PT) begin
         n_fail++; $display("FAIL pause_enter outs got %h want %h", outs, PT);
      end
      timer_end = 1'b1; goal_hit = 1'b1; restart = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (outs !== PT || lives !== 2'd3 || level !== 3'd2) begin
            n_fail++; $display("FAIL pause_hold%0d outs=%h lives=%0d lvl=%0d want %h/3/2", i, outs, lives, level, PT);
         end
      end
      timer_end = 1'b0; goal_hit = 1'b0; restart = 1'b0;
      pause_req = 1'b1; tick(); pause_req = 1'b0;
      n_chk++;
      if (outs !== NONE) begin
         n_fail++; $display("FAIL pause_resume outs got %h want %h", outs, NONE);
      end
      restart = 1'b1; tick(); restart = 1'b0;
      n_chk++;
      if (outs !== NONE || level !== 3'd2) begin
         n_fail++; $display("FAIL pause_restart_ignored outs=%h lvl=%0d want %h/2", outs, level, NONE);
      end
      pause_req = 1'b1; tick(); pause_req = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      n_chk++;
      if (outs !== DM || level !== 3'd1 || lives !== 2'd3 || retry_count !== 4'd0) begin
         n_fail++; $display("FAIL pause_reset outs=%h lvl=%0d lives=%0d retry=%0d want %h/1/3/0",
                            outs, level, lives, retry_count, DM);
      end
   endtask

   initial begin
      reset = 1'b1; start_of_frame = 1'b0; timer_end = 1'b0; goal_hit = 1'b0;
      pause_req = 1'b0; restart = 1'b0; place_coll = 5'b0;
      test_reset();
      test_clean_start();
      test_retry();
      test_life_loss();
      test_progression();
      test_priority();
      test_pause();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/game_controller_gen.md
Name: game_controller_gen

Overview:
- Parametrised top-level game-flow FSM: sequences maze draw, object placement with verified retry, play, pause, level progression, life loss, win/lose, and restart.
- Sits between the frame/timer/collision logic and the maze/object drawers and HUD.
- Generalises the single-configuration controller with:
  - configurable level and life counts;
  - a vector of placement-collision channels with a mask;
  - a bounded placement-retry count that falls back to a maze redraw;
  - pause, bonus lives, and restart after game end.

Parameters:
- NUM_LEVELS, 5, last playable level; levels are numbered 1..NUM_LEVELS.
- MAX_LIVES, 3, lives at start; ceiling for bonus lives.
- NUM_COLL, 5, width of the placement-collision vector.
- COLL_MASK, all ones (NUM_COLL bits), bit=1 means that channel blocks placement.
- PLACE_RETRY_MAX, 8, failed checks before the maze is regenerated (must be >=1).
- BONUS_EVERY, 2, a bonus life is granted every BONUS_EVERY completed levels; 0 disables bonus lives.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_of_frame  in  1  one-cycle pulse at the start of each frame scan
- timer_end  in  1  level timer expired
- goal_hit  in  1  machine-to-patient collision (level goal reached)
- place_coll  in  NUM_COLL  per-channel object-placement collision flags
- pause_req  in  1  one-cycle pulse that toggles pause
- restart  in  1  one-cycle pulse; restarts the game from WIN or LOSE
- level  out  $clog2(NUM_LEVELS+1)  current level
- lives  out  $clog2(MAX_LIVES+1)  remaining lives
- draw_maze  out  1  high while in DRAW_MAZE
- draw_objects  out  1  high while in DRAW_OBJ
- start_timer  out  1  one-cycle pulse on entering PLAY from CHECK
- pause_timer  out  1  high while in PAUSE
- completed_level  out  1  one-cycle pulse in LEVEL_UP
- lose_life  out  1  one-cycle pulse on life decrement
- maze_regen  out  1  one-cycle pulse when the retry limit forces a maze redraw
- retry_count  out  $clog2(PLACE_RETRY_MAX+1)  failed checks since the last maze draw
- flag_win  out  1  high while in WIN
- flag_lose  out  1  high while in LOSE

Behaviour:
- All state and counters are registered on posedge clk. Outputs are Moore-decoded from state or registered pulses; there is no combinational input-to-output path.
- reset (synchronous, highest priority): state=DRAW_MAZE, level=1, lives=MAX_LIVES, retry_count=0, levels_done=0. All pulse and flag outputs are 0.
  - Note: draw_maze reads 1 in the first cycle after reset, because it decodes DRAW_MAZE.
- States: DRAW_MAZE, DRAW_OBJ, CHECK, PLAY, PAUSE, LEVEL_UP, LIFE_LOST, LOSE, WIN.
- Define hit = |(place_coll & COLL_MASK).
- DRAW_MAZE: lasts exactly 1 cycle, then DRAW_OBJ. retry_count is cleared on this transition.
- DRAW_OBJ: on start_of_frame, go to CHECK; otherwise hold. place_coll is ignored here.
- CHECK (evaluated in this priority order):
  1. hit and retry_count == PLACE_RETRY_MAX-1: go to DRAW_MAZE with maze_regen=1.
  2. hit: go to DRAW_OBJ, retry_count+1.
  3. start_of_frame with no hit: go to PLAY with start_timer=1. retry_count holds its value.
  - If hit and start_of_frame arrive in the same cycle, hit wins.
- PLAY (priority: timer_end > goal_hit > pause_req):
  - timer_end: lose_life=1, lives-1.
    - If lives was >1 before the decrement: go to LIFE_LOST.
    - Otherwise: go to LOSE.
  - goal_hit: if level==NUM_LEVELS, go to WIN; otherwise go to LEVEL_UP.
  - pause_req: go to PAUSE.
- PAUSE: pause_timer=1. timer_end and goal_hit are ignored. pause_req returns to PLAY with no new start_timer.
- LIFE_LOST: 1 cycle, then DRAW_MAZE; the same level is redrawn.
- LEVEL_UP: 1 cycle, completed_level=1, level+1 and levels_done+1 visible next cycle, then DRAW_MAZE.
  - Bonus life: if BONUS_EVERY!=0 and (levels_done+1) % BONUS_EVERY == 0, lives+1, saturating at MAX_LIVES.
- LOSE / WIN: terminal; all inputs are ignored except restart.
  - restart: level=1, lives=MAX_LIVES, levels_done=0, go to DRAW_MAZE.
  - restart in any other state is ignored.
- Widths:
  - lives never underflows; LOSE is entered with lives==0.
  - level never exceeds NUM_LEVELS.
  - retry_count never reaches PLACE_RETRY_MAX.
- reset mid-operation (any state, including PAUSE/CHECK) aborts immediately to the reset values.

Test Plan:
- Clean start: reset, no hits, start_of_frame every 10 cycles -> DRAW_MAZE(1 cyc) -> DRAW_OBJ -> CHECK -> PLAY with a single start_timer pulse; level=1, lives=3.
- Retry fallback (PLACE_RETRY_MAX=8): hold place_coll[2]=1 -> retry_count counts 1..7, then maze_regen pulses; retry_count=0 and draw_maze=1 next cycle. A masked channel (COLL_MASK bit 0 = 0) with place_coll[0]=1 -> no retry.
- Life loss: timer_end in PLAY three times -> lives 3->2->1->0; lose_life pulses each time; third leads to LOSE with flag_lose=1; restart -> level=1, lives=3, DRAW_MAZE.
- Progression and bonus: start from lives=2 (after one timer_end); goal_hit at levels 1..5 -> completed_level pulses ×4, lives 2 -> 3 after level 2 and stays 3 (saturated) after level 4; at level 5, goal_hit leads to WIN.
- Priority: timer_end, goal_hit and pause_req all high in one PLAY cycle -> only the life loss occurs; hit and start_of_frame together in CHECK -> DRAW_OBJ, no start_timer.
- Pause: pause_req in PLAY -> pause_timer=1; timer_end/goal_hit ignored for 20 cycles; pause_req -> PLAY; a synchronous reset asserted during PAUSE -> reset values next cycle.
